inst_prefetch_mem: RTL and testbench

//  Parametrised instruction memory with a built-in prefetch queue for the ARM pipeline fetch stage.

---
 rtl/inst_prefetch_mem.sv | 122 ++++++++++++
 tb/tb_inst_prefetch_mem.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_mem.sv
`default_nettype none
// ============================================================================
// Module      : inst_prefetch_mem
// Description : Loader-writable instruction memory that streams sequential
//               words into a small prefetch queue with valid/ready output
//               and branch/exception redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_prefetch_mem #(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 256,
    parameter int                ADDR_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [DATA_W-1:0] NOP_WORD   = 32'hE000_0000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load_en,
    input  logic [ADDR_W-1:0]                 load_addr,
    input  logic [DATA_W-1:0]                 load_data,
    input  logic                              flush,
    input  logic [ADDR_W-1:0]                 flush_pc,
    input  logic                              fetch_ready,
    output logic                              inst_valid,
    output logic [DATA_W-1:0]                 inst_out,
    output logic [ADDR_W-1:0]                 inst_pc,
    output logic [$clog2(FIFO_DEPTH):0]       q_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_d   [FIFO_DEPTH];

    logic              pop;
    logic              issue;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_in_range;
    logic [DATA_W-1:0] rd_word;
    logic [ADDR_W-1:0] ld_idx;
    logic              mem_we;

    // Word indices keep the full address width so out-of-range detection
    // sees every upper bit, not just the bits that address the array.
    assign rd_idx      = fetch_pc_q >> 2;
    assign ld_idx      = load_addr >> 2;
    assign rd_in_range = (rd_idx < ADDR_W'(DEPTH));
    assign rd_word     = rd_in_range ? mem[rd_idx[IDX_W-1:0]] : NOP_WORD;
    assign mem_we      = load_en && !rst && (ld_idx < ADDR_W'(DEPTH));

    assign pop   = (count_q != '0) && fetch_ready;
    assign issue = !rst && !flush && !load_en &&
                   ((count_q - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ld_idx[IDX_W-1:0]] <= load_data;
        end
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        fifo_data_d = fifo_data_q;
        fifo_pc_d   = fifo_pc_q;

        if (rst || flush || load_en) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = (!rst && flush) ? flush_pc : RESET_PC;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (issue) begin
                fifo_data_d[wr_ptr_q] = rd_word;
                fifo_pc_d[wr_ptr_q]   = fetch_pc_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
                fetch_pc_d            = fetch_pc_q + ADDR_W'(4);
            end
            count_d = count_q + CNT_W'(issue) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
        // Queue payload needs no reset: occupancy gates everything visible.
        fifo_data_q <= fifo_data_d;
        fifo_pc_q   <= fifo_pc_d;
    end

    assign inst_valid = (count_q != '0);
    assign inst_out   = inst_valid ? fifo_data_q[rd_ptr_q] : NOP_WORD;
    assign inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q] : '0;
    assign q_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_prefetch_mem
// Description : Directed self-checking bench for inst_prefetch_mem.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_prefetch_mem;

    localparam logic [31:0] NOP  = 32'hE000_0000;
    localparam logic [31:0] BASE = 32'hE3A0_0000;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_ready;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [2:0]  q_count;

    int n_assert;
    int n_fail;

    inst_prefetch_mem #(
        .DATA_W     (32),
        .DEPTH      (256),
        .ADDR_W     (32),
        .FIFO_DEPTH (4),
        .RESET_PC   (32'h0),
        .NOP_WORD   (32'hE000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .fetch_ready (fetch_ready),
        .inst_valid  (inst_valid),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .q_count     (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        load_en     = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        flush       = 1'b0;
        flush_pc    = '0;
        fetch_ready = 1'b0;
        tick();
        tick();

        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_count", q_count, 3'd0);
        chk("rst_out",   inst_out, NOP);
        chk("rst_pc",    inst_pc, 32'h0);

        // Program load, including the last word and one beyond the end
        rst     = 1'b0;
        load_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            load_addr = 32'(i * 4);
            load_data = BASE + 32'(i);
            tick();
        end
        load_addr = 32'h3FC;
        load_data = 32'hE1A0_00FF;
        tick();
        load_addr = 32'h400;
        load_data = 32'hDEAD_BEEF;
        tick();
        chk("load_count", q_count, 3'd0);

        load_en     = 1'b0;
        fetch_ready = 1'b1;
        chk("t1_first_cycle_valid", inst_valid, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t1_valid", inst_valid, 1'b1);
            chk("t1_pc",    inst_pc, 32'(k * 4));
            chk("t1_out",   inst_out, BASE + 32'(k));
        end

        // Back-pressure fills the queue, then drains without gaps
        rst         = 1'b1;
        fetch_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("t2_count_1", q_count, 3'd1);
        for (int i = 0; i < 9; i++) tick();
        chk("t2_count_sat", q_count, 3'd4);
        chk("t2_head_pc",   inst_pc, 32'h0);
        fetch_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("t2_valid", inst_valid, 1'b1);
            chk("t2_pc",    inst_pc, 32'(k * 4));
            chk("t2_out",   inst_out, BASE + 32'(k));
            tick();
        end

        // Flush with three entries queued
        rst         = 1'b1;
        fetch_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("t3_count_3", q_count, 3'd3);
        flush    = 1'b1;
        flush_pc = 32'h10;
        tick();
        flush = 1'b0;
        chk("t3_valid_c1", inst_valid, 1'b0);
        chk("t3_count_c1", q_count, 3'd0);
        tick();
        chk("t3_valid_c2", inst_valid, 1'b1);
        chk("t3_pc_c2",    inst_pc, 32'h10);
        chk("t3_out_c2",   inst_out, BASE + 32'd4);
        fetch_ready = 1'b1;
        tick();
        chk("t3_pc_next",  inst_pc, 32'h14);
        chk("t3_out_next", inst_out, BASE + 32'd5);

        // Run off the end of the program memory
        flush    = 1'b1;
        flush_pc = 32'h3FC;
        tick();
        flush = 1'b0;
        chk("t4_valid_c1", inst_valid, 1'b0);
        tick();
        chk("t4_pc_last",  inst_pc, 32'h3FC);
        chk("t4_out_last", inst_out, 32'hE1A0_00FF);
        tick();
        chk("t4_pc_oor",   inst_pc, 32'h400);
        chk("t4_out_oor",  inst_out, NOP);
        tick();
        chk("t4_pc_oor2",  inst_pc, 32'h404);
        chk("t4_out_oor2", inst_out, NOP);

        // Reset mid-stream with ready toggling
        for (int i = 0; i < 4; i++) begin
            fetch_ready = (i % 2) == 1;
            tick();
        end
        rst         = 1'b1;
        fetch_ready = 1'b1;
        tick();
        chk("t5_valid", inst_valid, 1'b0);
        chk("t5_count", q_count, 3'd0);
        chk("t5_out",   inst_out, NOP);
        chk("t5_pc",    inst_pc, 32'h0);
        rst = 1'b0;
        tick();
        chk("t5_restart_pc",  inst_pc, 32'h0);
        chk("t5_restart_out", inst_out, BASE);
        tick();
        chk("t5_next_pc",  inst_pc, 32'h4);
        chk("t5_next_out", inst_out, BASE + 32'd1);

        // Flush and load in the same cycle
        load_en   = 1'b1;
        load_addr = 32'h20;
        load_data = 32'hE281_1001;
        flush     = 1'b1;
        flush_pc  = 32'h20;
        tick();
        load_en = 1'b0;
        flush   = 1'b0;
        chk("t6_valid_c1", inst_valid, 1'b0);
        tick();
        chk("t6_pc",       inst_pc, 32'h20);
        chk("t6_out",      inst_out, 32'hE281_1001);
        tick();
        chk("t6_next_pc",  inst_pc, 32'h24);
        chk("t6_next_out", inst_out, BASE + 32'd9);

        // Fetch address wraps past the top of the address space
        flush    = 1'b1;
        flush_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        tick();
        chk("wrap_pc_top",  inst_pc, 32'hFFFF_FFFC);
        chk("wrap_out_top", inst_out, NOP);
        tick();
        chk("wrap_pc_0",    inst_pc, 32'h0);
        chk("wrap_out_0",   inst_out, BASE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
